// File: rtl/pll_clock_manager_if.sv
// Signal bundle between the post-PLL clock/reset manager and the logic it serves.
// The manager owns the slave side; whoever drives lock, divisors and load
// strobes (top level or bench) owns the master side.
interface pll_clock_manager_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 16
);

  logic                    pll_locked;
  logic [NUM_CH*DIV_W-1:0] div;
  logic                    div_load;
  logic                    sys_reset;
  logic                    ready;
  logic [NUM_CH-1:0]       ce;
  logic [7:0]              lock_loss_cnt;

  modport master (
    output pll_locked, div, div_load,
    input  sys_reset, ready, ce, lock_loss_cnt
  );

  modport slave (
    input  pll_locked, div, div_load,
    output sys_reset, ready, ce, lock_loss_cnt
  );

endinterface

// File: rtl/pll_clock_manager.sv
// Post-PLL clock/reset manager.
// Filters the raw PLL lock, sequences a clean synchronous system reset and
// produces NUM_CH run-time divisible clock-enable strobes in the PLL domain.
// Optional feature macro: LOCK_MONITOR_EN
//   defined   : loss of lock in HOLD/RUN drops back to WAIT_LOCK and is counted
//   undefined : once HOLD is reached lock loss is ignored until reset,
//               lock_loss_cnt is tied to zero
module pll_clock_manager #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int RESET_HOLD  = 8,
  parameter int DIV_INIT    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  pll_clock_manager_if.slave      bus
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES) + 1;
  localparam int HOLD_W = $clog2(RESET_HOLD) + 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic              r_sync1;
  logic              r_lkS;
  state_t            r_state;
  state_t            w_nextState;
  logic [LOCK_W-1:0] r_lockCnt;
  logic [LOCK_W-1:0] w_lockCntNext;
  logic [HOLD_W-1:0] r_holdCnt;
  logic [HOLD_W-1:0] w_holdCntNext;
  logic              r_sysReset;
  logic              r_ready;

  logic [DIV_W-1:0]  r_div   [NUM_CH];
  logic [DIV_W-1:0]  r_chCnt [NUM_CH];
  logic [NUM_CH-1:0] w_wrap;
  logic [NUM_CH-1:0] w_ce;

`ifdef LOCK_MONITOR_EN
  logic              w_lossEvent;
  logic [7:0]        r_lossCnt;
`endif

  // Lock synchronizer, FSM state, sequencing counters and registered reset/ready
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_lkS      <= 1'b0;
      r_state    <= WAIT_LOCK;
      r_lockCnt  <= '0;
      r_holdCnt  <= '0;
      r_sysReset <= 1'b1;
      r_ready    <= 1'b0;
    end else begin
      r_sync1    <= bus.pll_locked;
      r_lkS      <= r_sync1;
      r_state    <= w_nextState;
      r_lockCnt  <= w_lockCntNext;
      r_holdCnt  <= w_holdCntNext;
      r_sysReset <= (w_nextState != RUN);
      r_ready    <= (w_nextState == RUN);
    end
  end

  // Next-state logic: qualify lock for LOCK_CYCLES, hold reset RESET_HOLD cycles, then run
  always_comb begin
    w_nextState   = r_state;
    w_lockCntNext = r_lockCnt;
    w_holdCntNext = r_holdCnt;
`ifdef LOCK_MONITOR_EN
    w_lossEvent   = 1'b0;
`endif
    unique case (r_state)
      WAIT_LOCK: begin
        w_lockCntNext = '0;
        w_holdCntNext = '0;
        if (r_lkS) begin
          w_nextState = STABLE;
        end
      end
      STABLE: begin
        if (!r_lkS) begin
          w_nextState   = WAIT_LOCK;
          w_lockCntNext = '0;
        end else if (r_lockCnt == LOCK_W'(LOCK_CYCLES - 1)) begin
          w_nextState   = HOLD;
          w_lockCntNext = '0;
          w_holdCntNext = '0;
        end else begin
          w_lockCntNext = r_lockCnt + LOCK_W'(1);
        end
      end
      HOLD: begin
        if (r_holdCnt == HOLD_W'(RESET_HOLD - 1)) begin
          w_nextState = RUN;
        end else begin
          w_holdCntNext = r_holdCnt + HOLD_W'(1);
        end
      end
      RUN: begin
        w_nextState = RUN;
      end
      default: begin
        w_nextState = WAIT_LOCK;
      end
    endcase
`ifdef LOCK_MONITOR_EN
    if (((r_state == HOLD) || (r_state == RUN)) && !r_lkS) begin
      w_nextState   = WAIT_LOCK;
      w_lockCntNext = '0;
      w_holdCntNext = '0;
      w_lossEvent   = 1'b1;
    end
`endif
  end

  // Wrap detection per channel; strobes only in RUN and never in a load cycle
  always_comb begin
    w_wrap = '0;
    w_ce   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_wrap[i] = (r_div[i] <= DIV_W'(1)) || (r_chCnt[i] >= (r_div[i] - DIV_W'(1)));
      w_ce[i]   = (r_state == RUN) && !bus.div_load && w_wrap[i];
    end
  end

  // Divisor registers and channel counters; a load restarts every channel at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_div[i]   <= DIV_W'(DIV_INIT);
        r_chCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.div_load) begin
          r_div[i] <= bus.div[i*DIV_W +: DIV_W];
        end
        if ((r_state != RUN) || bus.div_load || w_wrap[i]) begin
          r_chCnt[i] <= '0;
        end else begin
          r_chCnt[i] <= r_chCnt[i] + DIV_W'(1);
        end
      end
    end
  end

`ifdef LOCK_MONITOR_EN
  // Saturating count of lock-loss events seen after lock qualification
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lossCnt <= 8'd0;
    end else if (w_lossEvent && (r_lossCnt != 8'hFF)) begin
      r_lossCnt <= r_lossCnt + 8'd1;
    end
  end

  assign bus.lock_loss_cnt = r_lossCnt;
`else
  assign bus.lock_loss_cnt = 8'd0;
`endif

  assign bus.sys_reset = r_sysReset;
  assign bus.ready     = r_ready;
  assign bus.ce        = w_ce;

endmodule

// File: tb/tb_pll_clock_manager.sv
// Bench for pll_clock_manager: directed lock/reset/divisor sequences, a divisor
// table, and a long randomized run compared against a cycle-count reference model.
module tb_pll_clock_manager;

  localparam int NUM_CH      = 2;
  localparam int DIV_W       = 16;
  localparam int LOCK_CYCLES = 16;
  localparam int RESET_HOLD  = 8;
  localparam int DIV_INIT    = 4;
  localparam int LATENCY     = 2 + LOCK_CYCLES + RESET_HOLD;
  localparam int RUN_AT      = LOCK_CYCLES + RESET_HOLD + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int numChecks = 0;
  int numFails  = 0;

  pll_clock_manager_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  pll_clock_manager #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK_CYCLES),
    .RESET_HOLD(RESET_HOLD), .DIV_INIT(DIV_INIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d0;
    int d1;
    int first0;
    int period0;
    int first1;
    int period1;
  } DivVector;

  DivVector vecs [4];

  // Reference model: lock tracked as a run length of synced-high cycles,
  // channels as RUN cycles elapsed since start or last load, taken modulo the divisor
  bit mQ0 = 0, mQ1 = 0;
  int mRunLen = 0;
  bit mArmed = 0;
  int mHoldAge = 0;
  int mLoss = 0;
  bit mRun = 0;
  int mDiv [NUM_CH] = '{DIV_INIT, DIV_INIT};
  int mPhase [NUM_CH] = '{0, 0};

  task automatic modelStep();
    bit lkPre;
    bit runOld;
    bit load;
    if (reset) begin
      mQ0 = 0; mQ1 = 0; mRunLen = 0; mArmed = 0; mHoldAge = 0; mLoss = 0; mRun = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        mDiv[i] = DIV_INIT;
        mPhase[i] = 0;
      end
      return;
    end
    lkPre  = mQ1;
    runOld = mRun;
    load   = bus.div_load;
`ifdef LOCK_MONITOR_EN
    if (!lkPre && (mRunLen >= LOCK_CYCLES + 1) && (mLoss < 255)) mLoss++;
    mRunLen = lkPre ? mRunLen + 1 : 0;
    if (mRunLen > RUN_AT) mRunLen = RUN_AT;
    mRun = (mRunLen >= RUN_AT);
`else
    if (mArmed) begin
      if (mHoldAge < RESET_HOLD) mHoldAge++;
    end else begin
      mRunLen = lkPre ? mRunLen + 1 : 0;
      if (mRunLen == LOCK_CYCLES + 1) begin
        mArmed = 1;
        mHoldAge = 0;
      end
    end
    mRun = mArmed && (mHoldAge >= RESET_HOLD);
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      mPhase[i] = (runOld && !load) ? mPhase[i] + 1 : 0;
      if (load) mDiv[i] = int'(bus.div[i*DIV_W +: DIV_W]);
    end
    mQ1 = mQ0;
    mQ0 = bus.pll_locked;
  endtask

  function automatic int modelCe();
    int r = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mRun && !bus.div_load && ((mDiv[i] <= 1) || ((mPhase[i] % mDiv[i]) == mDiv[i] - 1)))
        r |= (1 << i);
    end
    return r;
  endfunction

  task automatic applyStimulus(input bit rst, input bit lock, input bit load, input int d0, input int d1);
    reset          = rst;
    bus.pll_locked = lock;
    bus.div_load   = load;
    bus.div        = {DIV_W'(d1), DIV_W'(d0)};
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    numChecks++;
    if (actual !== required) begin
      numFails++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, required);
    end
  endtask

  // One clock: model follows the edge, outputs are read in the low phase
  task automatic stepCycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    #1;
  endtask

  // Edge index (0 = first edge after the call) at which sys_reset falls / ready rises
  task automatic waitRelease(output int srEdge, output int rdyEdge);
    srEdge  = -1;
    rdyEdge = -1;
    for (int k = 0; k < LATENCY + 20; k++) begin
      stepCycle();
      if ((srEdge < 0) && (bus.sys_reset === 1'b0)) srEdge = k;
      if ((rdyEdge < 0) && (bus.ready === 1'b1)) rdyEdge = k;
      if ((srEdge >= 0) && (rdyEdge >= 0)) break;
    end
  endtask

  // First strobe cycle (current cycle = 1) and spacing to the next, per channel
  task automatic measureCe(output int f0, output int p0, output int f1, output int p1);
    int s0, s1;
    f0 = -1; f1 = -1; s0 = -1; s1 = -1;
    for (int c = 1; c <= 40; c++) begin
      if (bus.ce[0] === 1'b1) begin
        if (f0 < 0) f0 = c; else if (s0 < 0) s0 = c;
      end
      if (bus.ce[1] === 1'b1) begin
        if (f1 < 0) f1 = c; else if (s1 < 0) s1 = c;
      end
      if ((s0 >= 0) && (s1 >= 0)) break;
      stepCycle();
    end
    p0 = (s0 >= 0) ? s0 - f0 : -1;
    p1 = (s1 >= 0) ? s1 - f1 : -1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual timeout, required completion");
    numFails++;
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    int srEdge, rdyEdge, f0, p0, f1, p1, dropLeft;
    bit rLock, rLoad, rRst;

    vecs[0] = '{d0: 4, d1: 1, first0: 4, period0: 4, first1: 1, period1: 1};
    vecs[1] = '{d0: 3, d1: 2, first0: 3, period0: 3, first1: 2, period1: 2};
    vecs[2] = '{d0: 0, d1: 5, first0: 1, period0: 1, first1: 5, period1: 5};
    vecs[3] = '{d0: 1, d1: 7, first0: 1, period0: 1, first1: 7, period1: 7};

    // Power-up: reset held four cycles with lock already high
    applyStimulus(1, 1, 0, 4, 4);
    repeat (4) stepCycle();
    checkOutput("reset sys_reset", bus.sys_reset, 1);
    checkOutput("reset ready", bus.ready, 0);
    checkOutput("reset ce", bus.ce, 0);
    checkOutput("reset lock_loss_cnt", bus.lock_loss_cnt, 0);
    applyStimulus(0, 1, 0, 4, 4);
    waitRelease(srEdge, rdyEdge);
    checkOutput("powerup sys_reset edge", srEdge, LATENCY);
    checkOutput("powerup ready edge", rdyEdge, LATENCY);

    // Glitchy lock: ten cycles high, one low, then high again
    applyStimulus(1, 1, 0, 4, 4);
    repeat (2) stepCycle();
    applyStimulus(0, 1, 0, 4, 4);
    repeat (10) stepCycle();
    applyStimulus(0, 0, 0, 4, 4);
    stepCycle();
    checkOutput("glitch still in reset", bus.sys_reset, 1);
    applyStimulus(0, 1, 0, 4, 4);
    waitRelease(srEdge, rdyEdge);
    checkOutput("glitch sys_reset edge", srEdge, LATENCY);
    checkOutput("glitch ready edge", rdyEdge, LATENCY);

    // Default divisors on first RUN cycles
    measureCe(f0, p0, f1, p1);
    checkOutput("init ch0 first", f0, DIV_INIT);
    checkOutput("init ch1 period", p1, DIV_INIT);

    // Divisor table: load in RUN, then time the first strobe and the period
    for (int v = 0; v < 4; v++) begin
      applyStimulus(0, 1, 1, vecs[v].d0, vecs[v].d1);
      #1;
      checkOutput("table load-cycle ce", bus.ce, 0);
      stepCycle();
      applyStimulus(0, 1, 0, vecs[v].d0, vecs[v].d1);
      #1;
      measureCe(f0, p0, f1, p1);
      checkOutput("table ch0 first", f0, vecs[v].first0);
      checkOutput("table ch0 period", p0, vecs[v].period0);
      checkOutput("table ch1 first", f1, vecs[v].first1);
      checkOutput("table ch1 period", p1, vecs[v].period1);
    end

    // Load colliding with a channel-0 wrap: load wins, new divisor 3 restarts the count
    applyStimulus(0, 1, 1, 4, 1);
    stepCycle();
    applyStimulus(0, 1, 0, 4, 1);
    repeat (3) stepCycle();
    checkOutput("collide wrap pending", bus.ce[0], 1);
    applyStimulus(0, 1, 1, 3, 1);
    #1;
    checkOutput("collide ce suppressed", bus.ce, 0);
    stepCycle();
    applyStimulus(0, 1, 0, 3, 1);
    #1;
    measureCe(f0, p0, f1, p1);
    checkOutput("collide ch0 next", f0, 3);
    checkOutput("collide ch0 period", p0, 3);

    // Lock loss while in RUN
    applyStimulus(0, 0, 0, 3, 1);
    repeat (3) stepCycle();
`ifdef LOCK_MONITOR_EN
    checkOutput("lockloss sys_reset", bus.sys_reset, 1);
    checkOutput("lockloss ready", bus.ready, 0);
    checkOutput("lockloss count", bus.lock_loss_cnt, 1);
    applyStimulus(0, 1, 0, 3, 1);
    waitRelease(srEdge, rdyEdge);
    checkOutput("relock ready edge", rdyEdge, LATENCY);
`else
    checkOutput("lockloss sys_reset", bus.sys_reset, 0);
    checkOutput("lockloss ready", bus.ready, 1);
    checkOutput("lockloss count", bus.lock_loss_cnt, 0);
    applyStimulus(0, 1, 0, 3, 1);
    repeat (4) stepCycle();
    checkOutput("relock ready kept", bus.ready, 1);
`endif

    // Reset in RUN with strobes active
    applyStimulus(1, 1, 0, 3, 1);
    stepCycle();
    checkOutput("runreset sys_reset", bus.sys_reset, 1);
    checkOutput("runreset ce", bus.ce, 0);
    checkOutput("runreset lock_loss_cnt", bus.lock_loss_cnt, 0);

    // Reset in HOLD after loading new divisors: divisors must return to DIV_INIT
    applyStimulus(0, 1, 0, 3, 1);
    repeat (LOCK_CYCLES + 4) stepCycle();
    checkOutput("hold sys_reset", bus.sys_reset, 1);
    applyStimulus(0, 1, 1, 2, 3);
    stepCycle();
    applyStimulus(1, 1, 0, 2, 3);
    stepCycle();
    checkOutput("holdreset sys_reset", bus.sys_reset, 1);
    checkOutput("holdreset ready", bus.ready, 0);
    checkOutput("holdreset ce", bus.ce, 0);
    applyStimulus(0, 1, 0, 2, 3);
    waitRelease(srEdge, rdyEdge);
    checkOutput("holdreset release edge", rdyEdge, LATENCY);
    measureCe(f0, p0, f1, p1);
    checkOutput("holdreset ch0 first", f0, DIV_INIT);
    checkOutput("holdreset ch1 first", f1, DIV_INIT);
    checkOutput("holdreset ch1 period", p1, DIV_INIT);

    // Randomized run against the reference model
    applyStimulus(1, 1, 0, 4, 4);
    repeat (2) stepCycle();
    dropLeft = 0;
    for (int n = 0; n < 4000; n++) begin
      rRst = ($urandom_range(0, 999) == 0);
      if (dropLeft > 0) begin
        rLock = 0;
        dropLeft--;
      end else begin
        rLock = 1;
        if ($urandom_range(0, 199) == 0) dropLeft = int'($urandom_range(1, 4));
      end
      rLoad = ($urandom_range(0, 19) == 0);
      applyStimulus(rRst, rLock, rLoad, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
      #1;
      checkOutput("rand ce", bus.ce, modelCe());
      checkOutput("rand sys_reset", bus.sys_reset, !mRun);
      checkOutput("rand ready", bus.ready, mRun);
`ifdef LOCK_MONITOR_EN
      checkOutput("rand lock_loss_cnt", bus.lock_loss_cnt, mLoss);
`else
      checkOutput("rand lock_loss_cnt", bus.lock_loss_cnt, 0);
`endif
      stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
